// File: rtl/noc_flit_pkg.sv
// noc_flit_pkg: flit encoding, field positions, error flag indices and node index helper
package noc_flit_pkg;
  localparam logic [1:0] FLIT_ILLEGAL = 2'b00;
  localparam logic [1:0] FLIT_HEAD    = 2'b01;
  localparam logic [1:0] FLIT_BODY    = 2'b10;
  localparam logic [1:0] FLIT_TAIL    = 2'b11;

  localparam int TYPE_HI = 31, TYPE_LO = 30;
  localparam int PRIO_HI = 29, PRIO_LO = 28;
  localparam int MSG_HI  = 27, MSG_LO  = 16;
  localparam int SRCX_HI = 15, SRCX_LO = 12;
  localparam int SRCY_HI = 11, SRCY_LO = 8;
  localparam int DSTX_HI = 7,  DSTX_LO = 4;
  localparam int DSTY_HI = 3,  DSTY_LO = 0;

  localparam int ERR_FRAME = 0;
  localparam int ERR_DEST  = 1;
  localparam int ERR_MSG   = 2;
  localparam int ERR_LEN   = 3;

  typedef enum logic {S_IDLE, S_IN_PKT} sink_state_e;

  function automatic int unsigned node_idx(input logic [3:0] x, input logic [3:0] y,
                                           input int unsigned dim);
    return 32'(y) * dim + 32'(x);
  endfunction
endpackage

// File: rtl/noc_stall_lfsr.sv
// noc_stall_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) giving ~75% ready duty
module noc_stall_lfsr (
  input  logic clk,
  input  logic rst,
  output logic ready_o
);
  logic [15:0] lfsr_q;
  // advance every cycle; restarts from the fixed seed on reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign ready_o = lfsr_q[1:0] != 2'b00;
endmodule

// File: rtl/node_packet_sink.sv
// node_packet_sink: router ejection consumer with framing/dest/msg-id/length checks and stats; NODE_SINK_STALL_LFSR_EN adds random backpressure
module node_packet_sink
  import noc_flit_pkg::*;
#(
  parameter int ID             = 0,
  parameter int DIM            = 3,
  parameter int FlitsPerPacket = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data_out,
  input  logic             valid_out,
  output logic             ready_out,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] flit_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       err_flags,
  output logic [11:0]      last_msg_id,
  output logic [7:0]       last_src,
  output logic [CNT_W-1:0] last_time,
  output logic             pkt_done
);
  localparam int unsigned ID_U  = ID;
  localparam int unsigned DIM_U = DIM;
  localparam int unsigned FPP_U = FlitsPerPacket;
  localparam int LEN_W = $clog2(FlitsPerPacket + 1) + 1;

  sink_state_e      state_q;
  logic [11:0]      msg_q, last_msg_q;
  logic [LEN_W-1:0] cnt_q, cnt_inc;
  logic [CNT_W-1:0] pkt_q, flit_q, err_q, cyc_q, last_time_q;
  logic [3:0]       flags_q, flit_err;
  logic [7:0]       last_src_q, src;
  logic [1:0]       typ;
  logic [11:0]      msg;
  logic             ready_q, ready_d, pkt_done_q, acc, in_pkt, tail_done, unused_prio;

`ifdef NODE_SINK_STALL_LFSR_EN
  noc_stall_lfsr u_stall (.clk(clk), .rst(rst), .ready_o(ready_d));
`else
  assign ready_d = 1'b1;
`endif

  assign typ         = data_out[TYPE_HI:TYPE_LO];
  assign msg         = data_out[MSG_HI:MSG_LO];
  assign unused_prio = ^data_out[PRIO_HI:PRIO_LO];
  assign src         = 8'(node_idx(data_out[SRCX_HI:SRCX_LO], data_out[SRCY_HI:SRCY_LO], DIM_U));
  assign acc         = valid_out & ready_q;
  assign in_pkt      = state_q == S_IN_PKT;
  assign tail_done   = in_pkt & (typ == FLIT_TAIL);
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // per-flit check results; only meaningful when the flit is accepted
  always_comb begin
    flit_err            = '0;
    flit_err[ERR_FRAME] = in_pkt ? (typ == FLIT_HEAD || typ == FLIT_ILLEGAL) : (typ != FLIT_HEAD);
    flit_err[ERR_DEST]  = node_idx(data_out[DSTX_HI:DSTX_LO], data_out[DSTY_HI:DSTY_LO], DIM_U) != ID_U;
    flit_err[ERR_MSG]   = in_pkt & typ[1] & (msg != msg_q);
    flit_err[ERR_LEN]   = in_pkt & ((typ == FLIT_BODY && 32'(cnt_inc) >= FPP_U) ||
                                    (typ == FLIT_TAIL && 32'(cnt_inc) != FPP_U));
  end

  // registered ready: low in reset, rises on the first edge after release
  always_ff @(posedge clk or negedge rst)
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= ready_d;

  // packet framing FSM; a head always (re)starts a packet, a tail in a packet ends it
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      msg_q   <= '0;
      cnt_q   <= '0;
    end else if (acc) begin
      if (typ == FLIT_HEAD) begin
        state_q <= S_IN_PKT;
        msg_q   <= msg;
        cnt_q   <= LEN_W'(1);
      end else if (tail_done) begin
        state_q <= S_IDLE;
        cnt_q   <= cnt_inc;
      end else if (in_pkt && typ == FLIT_BODY) begin
        cnt_q   <= cnt_inc;
      end
    end

  // statistics, sticky flags and last completed packet record; clr_stats beats a same-cycle accept
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cyc_q       <= '0;
      pkt_q       <= '0;
      flit_q      <= '0;
      err_q       <= '0;
      flags_q     <= '0;
      last_msg_q  <= '0;
      last_src_q  <= '0;
      last_time_q <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      cyc_q      <= cyc_q + 1'b1;
      pkt_done_q <= acc & tail_done;
      if (acc && tail_done) begin
        last_msg_q  <= msg_q;
        last_src_q  <= src;
        last_time_q <= cyc_q;
      end
      if (clr_stats) begin
        pkt_q   <= '0;
        flit_q  <= '0;
        err_q   <= '0;
        flags_q <= '0;
      end else if (acc) begin
        pkt_q   <= pkt_q + CNT_W'(tail_done);
        flit_q  <= flit_q + 1'b1;
        err_q   <= err_q + CNT_W'(|flit_err);
        flags_q <= flags_q | flit_err;
      end
    end

  assign ready_out   = ready_q;
  assign pkt_count   = pkt_q;
  assign flit_count  = flit_q;
  assign err_count   = err_q;
  assign err_flags   = flags_q;
  assign last_msg_id = last_msg_q;
  assign last_src    = last_src_q;
  assign last_time   = last_time_q;
  assign pkt_done    = pkt_done_q;
endmodule

// File: doc/node_packet_sink.md
Name: node_packet_sink

Overview:
- Synthesizable ejection-side consumer attached directly to a router node's local output port (data_out/valid_out/ready_out channel).
- Accepts flits and checks packet framing, destination and per-packet flit count.
- Keeps packet, flit and error statistics, and captures the arrival record of each completed packet.
- Replaces the simulation-only output logging when running on FPGA or in long regressions.

Parameters:
- ID, 0, node index of the attached router; expected destination for every flit.
- DIM, 3, mesh dimension; node index = y*DIM + x.
- FlitsPerPacket, 16, required flits per packet, head and tail included; must be >= 2.
- CNT_W, 32, width of every statistic and timestamp counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- data_out  in  32  flit from router
- valid_out  in  1  flit valid from router
- ready_out  out  1  sink ready to router
- clr_stats  in  1  synchronous clear of counters and sticky errors
- pkt_count  out  CNT_W  completed packets (tail accepted)
- flit_count  out  CNT_W  accepted flits
- err_count  out  CNT_W  erroneous flits
- err_flags  out  4  sticky: [0] framing, [1] dest mismatch, [2] msg-id mismatch, [3] length
- last_msg_id  out  12  message id of last completed packet
- last_src  out  8  source node index of last completed packet
- last_time  out  CNT_W  cycle counter value when that tail was accepted
- pkt_done  out  1  one-cycle pulse, the cycle after the tail handshake

Behaviour:
- Flit fields:
  - [31:30] type: 01 head, 10 body, 11 tail, 00 illegal.
  - [29:28] priority; [27:16] msg id.
  - [15:12]/[11:8] src x/y; [7:4]/[3:0] dest x/y.
  - Dest index = data[3:0]*DIM + data[7:4]; src index = data[11:8]*DIM + data[15:12].
- Handshake: a flit is accepted when valid_out & ready_out at the rising clock edge. ready_out is registered. Without STALL_LFSR_EN it is 1 in every cycle after reset release.
- Reset (rst=0, asynchronous): all outputs 0, FSM IDLE, internal cycle counter 0. ready_out rises at the first clock edge after rst deasserts.
- Cycle counter: free-running, wraps modulo 2^CNT_W.
- FSM state IDLE:
  - head → capture msg id, set flit cnt=1, go to IN_PKT.
  - body/tail/illegal → framing error, stay IDLE.
- FSM state IN_PKT:
  - body → cnt+1.
  - tail → cnt+1, run the length check, go to IDLE, update last_* regs, pulse pkt_done.
  - head → framing error; treat as a new packet start by recapturing msg id and setting cnt=1.
  - illegal → framing error, stay in IN_PKT.
- Length check: at tail, cnt+1 != FlitsPerPacket → length error.
- Body flit count overflow: if cnt reaches FlitsPerPacket on a body flit → length error; keep counting, saturating.
- Msg-id check: a body/tail whose msg id differs from the captured id → msg-id error.
- Dest check: any accepted flit with dest index != ID → dest error.
- Error accounting:
  - err_count increments at most once per accepted flit, even when several checks fail on that flit.
  - The relevant err_flags bits are set together.
- Completed packet: pkt_count increments on every accepted tail in IN_PKT, including packets flagged with errors. A tail in IDLE does not count.
- Output timing: counters update 1 cycle after the accepting edge (registered).
- clr_stats:
  - Zeroes pkt/flit/err counts and err_flags next edge; FSM is unaffected.
  - If an accept coincides with clr_stats, the clear wins and the flit is not counted. It is still processed by the FSM.
- Wrap: all statistic counters wrap modulo 2^CNT_W, with no saturation.
- Reset mid-packet: FSM returns to IDLE. Trailing body/tail flits after reset release raise framing errors.

Optional Feature:
- Macro: NODE_SINK_STALL_LFSR_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - ready_out <= ~(lfsr[1:0] == 2'b00), giving about 25% backpressure to exercise router output buffering.
- When undefined: no LFSR is instantiated and ready_out is constant 1 after reset.

Decomposition:
- Shared package noc_flit_pkg:
  - Localparams FLIT_HEAD=2'b01, FLIT_BODY=2'b10, FLIT_TAIL=2'b11, FLIT_ILLEGAL=2'b00.
  - Field bit positions, ERR_* flag indices.
  - A function computing node index from (x,y,DIM).
- Sub-module: noc_stall_lfsr, the backpressure generator, reused later by an injector.

Test Plan:
- ID=4, DIM=3, FlitsPerPacket=4; inject head 0x4005_0011, two bodies 0x8005_0011, tail 0xC005_0011 → pkt_count=1, flit_count=4, err_flags=0, last_msg_id=5, last_src=0, pkt_done single pulse.
- Body 0x8001_0011 with FSM in IDLE → err_flags[0]=1, err_count=1, pkt_count=0.
- Packet of 3 flits (head, body, tail) with FlitsPerPacket=4 → err_flags[3]=1, pkt_count=1.
- Head dest field 0x00 with ID=4 → err_flags[1]=1 on each of 4 flits, err_count=4.
- Body msg id 6 inside a packet with msg id 5 → err_flags[2]=1; assert clr_stats the next cycle → all counters and flags 0.
- Assert rst low mid-packet for 1 cycle, then send the remaining tail → ready_out=0 during reset, framing error after release. With NODE_SINK_STALL_LFSR_EN and 1000 cycles of valid_out=1: ready_out low for 200-300 cycles, flit_count equals the high cycles.
